// File: rtl/fmlbrg_tagflush.sv
// Flush/invalidate sequencer for the FML bridge cache tag memory.
// Walks every tag index, writes back valid+dirty lines, then rewrites each entry.
module fmlbrg_tagflush #(
  parameter int unsigned depth = 2,
  parameter int unsigned width = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    flush_req,
  input  logic                    flush_inval,
  output logic                    flush_busy,
  output logic                    flush_done,
  output logic [depth-1:0]        tm_a,
  output logic                    tm_we,
  output logic [width-1:0]        tm_di,
  input  logic [width-1:0]        tm_do,
  output logic                    wb_stb,
  output logic [width-2+depth-1:0] wb_adr,
  input  logic                    wb_ack
);

  localparam logic [depth-1:0] LastIdx = '1;

  typedef enum logic [2:0] {StIdle, StAddr, StRead, StWb, StWrite, StDone} state_e;

  state_e           state_q, state_d;
  logic [depth-1:0] index_q, index_d;
  // Only valid bit and address tag are kept; the dirty bit is always cleared on write.
  logic [width-2:0] entry_q, entry_d;
  logic             inval_q, inval_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      index_q <= '0;
      entry_q <= '0;
      inval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      entry_q <= entry_d;
      inval_q <= inval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    entry_d = entry_q;
    inval_d = inval_q;
    unique case (state_q)
      StIdle: begin
        if (flush_req) begin
          inval_d = flush_inval;
          index_d = '0;
          state_d = StAddr;
        end
      end
      StAddr: state_d = StRead;
      StRead: begin
        entry_d = {tm_do[width-1], tm_do[width-3:0]};
        state_d = (tm_do[width-1] && tm_do[width-2]) ? StWb : StWrite;
      end
      StWb: begin
        if (wb_ack) state_d = StWrite;
      end
      StWrite: begin
        // Last index ends the walk without wrapping back to 0.
        if (index_q == LastIdx) begin
          state_d = StDone;
        end else begin
          index_d = index_q + depth'(1);
          state_d = StAddr;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    flush_busy = (state_q != StIdle);
    flush_done = 1'b0;
    tm_a       = '0;
    tm_we      = 1'b0;
    tm_di      = '0;
    wb_stb     = 1'b0;
    wb_adr     = '0;
    if (state_q != StIdle) tm_a = index_q;
    unique case (state_q)
      StWb: begin
        wb_stb = 1'b1;
        wb_adr = {entry_q[width-3:0], index_q};
      end
      StWrite: begin
        tm_we = 1'b1;
        tm_di = inval_q ? '0 : {entry_q[width-2], 1'b0, entry_q[width-3:0]};
      end
      StDone: flush_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fmlbrg_tagflush.sv
// Scoreboard bench for fmlbrg_tagflush: expected writes, writebacks and done timing are
// planned from the tag contents and checked by an independent monitor.
module tb_fmlbrg_tagflush;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       flush_req = 1'b0;
  logic       flush_inval = 1'b0;
  logic       flush_busy, flush_done, tm_we, wb_stb;
  logic [1:0] tm_a;
  logic [3:0] tm_di;
  logic [3:0] tm_do = 4'd0;
  logic [3:0] wb_adr;
  logic       wb_ack = 1'b0;

  fmlbrg_tagflush #(.depth(2), .width(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .flush_req  (flush_req),
    .flush_inval(flush_inval),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .tm_a       (tm_a),
    .tm_we      (tm_we),
    .tm_di      (tm_di),
    .tm_do      (tm_do),
    .wb_stb     (wb_stb),
    .wb_adr     (wb_adr),
    .wb_ack     (wb_ack)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start = 0;
  int ack_dly = 0;
  bit noise_en = 1'b0;
  int stb_cnt = 0;

  logic [3:0] mem [4];
  logic [3:0] fin [4];

  int exp_wr_idx[$], exp_wr_dat[$], exp_wr_cyc[$];
  int exp_wb_adr[$], exp_wb_cyc[$];
  int exp_done[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Tag memory: registered read-first port.
  always @(posedge sys_clk) begin
    tm_do <= mem[tm_a];
    if (tm_we) mem[tm_a] = tm_di;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Writeback engine: acks ack_dly cycles after wb_stb rises; optional noise while idle.
  always @(negedge sys_clk) begin
    if (wb_stb) begin
      wb_ack  <= (stb_cnt == ack_dly);
      stb_cnt <= stb_cnt + 1;
    end else begin
      wb_ack  <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      stb_cnt <= 0;
    end
  end

  logic       stb_prev = 1'b0;
  logic [3:0] held_adr = 4'd0;
  int         mcyc;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      stb_prev = 1'b0;
    end else begin
      mcyc = cyc - start + 1;
      if (!flush_busy)
        chk("idle_quiet", {25'd0, tm_we, wb_stb, flush_done, 2'd0, tm_a}, 32'd0);
      if (tm_we) begin
        if (exp_wr_idx.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          chk("write_index", 32'(tm_a), 32'(exp_wr_idx.pop_front()));
          chk("write_data", 32'(tm_di), 32'(exp_wr_dat.pop_front()));
          chk("write_cycle", 32'(mcyc), 32'(exp_wr_cyc.pop_front()));
        end
      end
      if (wb_stb && !stb_prev) begin
        held_adr = wb_adr;
        if (exp_wb_adr.size() == 0) chk("unexpected_wb", 32'd1, 32'd0);
        else begin
          chk("wb_adr", 32'(wb_adr), 32'(exp_wb_adr.pop_front()));
          chk("wb_cycle", 32'(mcyc), 32'(exp_wb_cyc.pop_front()));
        end
      end else if (wb_stb) begin
        chk("wb_adr_stable", 32'(wb_adr), 32'(held_adr));
      end
      stb_prev = wb_stb;
      if (flush_done) begin
        chk("done_busy", 32'(flush_busy), 32'd1);
        if (exp_done.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          chk("done_cycle", 32'(mcyc), 32'(exp_done.pop_front()));
          chk("wb_all_seen", 32'(exp_wb_adr.size()), 32'd0);
          chk("wr_all_seen", 32'(exp_wr_idx.size()), 32'd0);
        end
      end
    end
  end

  // Reference plan: per index ADDR, READ, optional (dly+1) WB cycles, WRITE.
  task automatic plan(input bit inval, input int dly);
    int t = 1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] e = mem[i];
      logic [1:0] ii = 2'(i);
      bit dirty = e[3] && e[2];
      int w;
      logic [3:0] wd;
      if (dirty) begin
        exp_wb_adr.push_back(int'({e[1:0], ii}));
        exp_wb_cyc.push_back(t + 2);
      end
      w = t + 2 + (dirty ? dly + 1 : 0);
      wd = inval ? 4'd0 : {e[3], 1'b0, e[1:0]};
      exp_wr_idx.push_back(i);
      exp_wr_dat.push_back(int'(wd));
      exp_wr_cyc.push_back(w);
      fin[i] = wd;
      t = w + 1;
    end
    exp_done.push_back(t);
  endtask

  task automatic kick(input bit hold, input bit inval);
    @(posedge sys_clk);
    #1 flush_req = 1'b1;
    flush_inval = inval;
    @(posedge sys_clk);
    #1 start = cyc;
    if (!hold) flush_req = 1'b0;
  endtask

  task automatic run_flush(input bit hold, input bit inval, input int dly, input bit noise);
    bit got = 1'b0;
    ack_dly = dly;
    noise_en = noise;
    plan(inval, dly);
    kick(hold, inval);
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge sys_clk);
      if (flush_done) got = 1'b1;
      else flush_inval = 1'($urandom_range(0, 1));
    end
    chk("done_seen", 32'(got), 32'd1);
    flush_req = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1 chk("busy_after_done", 32'(flush_busy), 32'd0);
    for (int i = 0; i < 4; i++) chk("final_entry", 32'(mem[i]), 32'(fin[i]));
    exp_done.delete();
    noise_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 4'd0;
    #3 chk("reset_busy", 32'(flush_busy), 32'd0);
    chk("reset_outs", {26'd0, tm_we, wb_stb, flush_done, tm_a, 1'b0}, 32'd0);
    #10 sys_rst_n = 1'b1;

    // All clean-invalid, invalidate.
    run_flush(1'b0, 1'b1, 0, 1'b0);
    // One dirty line, ack two cycles after strobe.
    mem[0] = 4'd0; mem[1] = 4'd0; mem[2] = 4'b1101; mem[3] = 4'd0;
    run_flush(1'b0, 1'b0, 2, 1'b0);
    // Valid clean line, stray acks.
    mem[1] = 4'b1001;
    run_flush(1'b0, 1'b0, 0, 1'b1);
    run_flush(1'b0, 1'b1, 0, 1'b1);
    // All dirty, immediate acks.
    for (int i = 0; i < 4; i++) mem[i] = {2'b11, 2'($urandom_range(0, 3))};
    run_flush(1'b0, 1'b0, 0, 1'b0);
    // Request held for the whole sequence.
    for (int i = 0; i < 4; i++) mem[i] = 4'($urandom_range(0, 15));
    run_flush(1'b1, 1'b0, 1, 1'b0);

    // Reset during WB.
    for (int i = 0; i < 4; i++) mem[i] = {2'b11, 2'($urandom_range(0, 3))};
    ack_dly = 6;
    plan(1'b0, 6);
    kick(1'b0, 1'b0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge sys_clk);
        if (wb_stb) seen = 1'b1;
      end
      chk("wb_reached", 32'(seen), 32'd1);
    end
    #2 sys_rst_n = 1'b0;
    #1 chk("rst_wb_stb", 32'(wb_stb), 32'd0);
    chk("rst_busy", 32'(flush_busy), 32'd0);
    chk("rst_tm_we", 32'(tm_we), 32'd0);
    exp_wr_idx.delete(); exp_wr_dat.delete(); exp_wr_cyc.delete();
    exp_wb_adr.delete(); exp_wb_cyc.delete(); exp_done.delete();
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    run_flush(1'b0, 1'b0, 1, 1'b0);

    // Randomized flushes.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) mem[i] = 4'($urandom_range(0, 15));
      run_flush(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
